// File: rtl/ripemd_sched_pkg.sv
// Shared widths, the fixed RIPEMD padding tail for a 32-byte message, and a clog2 helper.
package ripemd_sched_pkg;

  localparam int BLOCK_W  = 512;
  localparam int HASH_W   = 160;
  localparam int DIGEST_W = 256;

  // 0x80 terminator, zero fill, then the 64-bit little-endian bit length (256 = 0x0100).
  localparam logic [DIGEST_W-1:0] PAD_TAIL = {8'h80, 184'h0, 8'h00, 8'h01, 48'h0};

  // Ceiling log2, never below 1 so it is always usable as a vector width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push while full is accepted when a pop frees a slot.
module sync_fifo
  import ripemd_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  // Head is forced to zero when empty so the output is clean out of reset.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ripemd_sched.sv
// Round-robin, credit-throttled front end sharing one in-order RIPEMD-160 core between requesters.
// Each issue is tagged with the requester id; tags pair up with core results in issue order.
module ripemd_sched
  import ripemd_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DEPTH = 8,
  parameter int IDW   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DIGEST_W-1:0] req_digest,
  output logic                      core_i_valid,
  output logic [BLOCK_W-1:0]        core_block,
  input  logic                      core_o_valid,
  input  logic [HASH_W-1:0]         core_ans,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [IDW-1:0]            res_id,
  output logic [HASH_W-1:0]         res_hash,
  output logic                      err_orphan
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int RW = IDW + HASH_W;

  logic [IDW-1:0]     p_q, p_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic               core_i_valid_q, core_i_valid_d;
  logic [BLOCK_W-1:0] core_block_q, core_block_d;
  logic               err_orphan_q, err_orphan_d;

  logic [CW-1:0]      occ, rf_count;
  logic               can_issue, gnt_vld, hs, ret;
  logic [IDW-1:0]     gnt_idx, idx;
  logic [IDW-1:0]     tag_head;
  logic               tag_empty, res_empty;
  logic [RW-1:0]      res_head;
  logic               tag_full_unused, res_full_unused;
  logic [CW-1:0]      tag_count_unused;

  // Credits cover both blocks inside the core and results parked in the result FIFO.
  assign occ       = inflight_q + rf_count;
  assign can_issue = (occ < CW'(DEPTH));

  // Round-robin pick: first valid at or after p, wrapping; scanning downward lets the nearest win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(p_q) + k) % N_REQ);
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign hs        = gnt_vld & can_issue;
  assign req_ready = hs ? (N_REQ'(1) << gnt_idx) : '0;
  assign ret       = core_o_valid & ~tag_empty;

  // Issue, pointer advance, credit accounting and orphan detection.
  always_comb begin
    core_i_valid_d = hs;
    core_block_d   = core_block_q;
    p_d            = p_q;
    if (hs) begin
      core_block_d = {req_digest[int'(gnt_idx)*DIGEST_W +: DIGEST_W], PAD_TAIL};
      p_d          = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    inflight_d   = inflight_q + CW'(hs) - CW'(ret);
    err_orphan_d = err_orphan_q | (core_o_valid & tag_empty);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q            <= '0;
      inflight_q     <= '0;
      core_i_valid_q <= 1'b0;
      core_block_q   <= '0;
      err_orphan_q   <= 1'b0;
    end else begin
      p_q            <= p_d;
      inflight_q     <= inflight_d;
      core_i_valid_q <= core_i_valid_d;
      core_block_q   <= core_block_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign core_i_valid = core_i_valid_q;
  assign core_block   = core_block_q;
  assign err_orphan   = err_orphan_q;

  // Requester ids of issued blocks, oldest first; the core returns in the same order.
  sync_fifo #(.WIDTH(IDW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hs),
    .din   (gnt_idx),
    .pop   (core_o_valid),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full_unused),
    .count (tag_count_unused)
  );

  // Tagged results awaiting the consumer.
  sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ret),
    .din   ({tag_head, core_ans}),
    .pop   (res_valid & res_ready),
    .dout  (res_head),
    .empty (res_empty),
    .full  (res_full_unused),
    .count (rf_count)
  );

  assign res_valid          = ~res_empty;
  assign {res_id, res_hash} = res_head;

endmodule

// File: tb/tb_ripemd_sched.sv
// Directed bench for ripemd_sched with an in-order fixed-latency core model.
module tb_ripemd_sched;
  localparam int N = 4, D = 8, IDW = 2, LAT = 3;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [159:0] KNOWN_H = 160'hb472a266d0bd89c13706a4132ccfb16f7c3b9fcb;
  localparam logic [255:0] TAIL    = {8'h80, 184'h0, 8'h00, 8'h01, 48'h0};

  logic               clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]       req_valid = '0, req_ready;
  logic [N*256-1:0]   req_digest = '0;
  logic               core_i_valid, core_o_valid, res_valid, err_orphan;
  logic               res_ready = 1'b0, inj = 1'b0;
  logic [511:0]       core_block;
  logic [159:0]       core_ans, res_hash;
  logic [IDW-1:0]     res_id;

  int checks = 0, failures = 0, cyc = 0;
  int hs_cyc, civ_cyc, ov_cyc, rv_cyc;
  logic rv_prev = 1'b0;
  logic [N-1:0] hs_n = '0;
  logic [255:0] pend[N][$];
  int grant_q[$];
  logic [255:0] idig_q[$];
  logic [511:0] blk_q[$];
  logic [IDW+159:0] res_q[$];

  ripemd_sched #(.N_REQ(N), .DEPTH(D), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_digest(req_digest), .core_i_valid(core_i_valid), .core_block(core_block),
    .core_o_valid(core_o_valid), .core_ans(core_ans), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_hash(res_hash), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] mk(input int i, input int k);
    return {8'(i), 8'(k), 16'hC0DE, {14{16'(i * 257 + k * 13 + 7)}}};
  endfunction

  // Core stand-in: the real hash for the empty-string digest, otherwise the digest's top 160 bits.
  function automatic logic [159:0] model_hash(input logic [255:0] d);
    return (d == EMPTY_D) ? KNOWN_H : d[255:96];
  endfunction

  logic [LAT-1:0] pv;
  logic [159:0]   pa [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 0; k < LAT; k++) pa[k] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], core_i_valid};
      pa[0] <= model_hash(core_block[511:256]);
      for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
    end
  end
  assign core_o_valid = pv[LAT-1] | inj;
  assign core_ans     = inj ? '0 : pa[LAT-1];

  // Observe handshakes, issues, returns and result pops mid-cycle.
  always @(negedge clk) begin
    hs_n = rst_n ? (req_valid & req_ready) : '0;
    if (rst_n) begin
      for (int i = 0; i < N; i++)
        if (hs_n[i]) begin
          grant_q.push_back(i);
          idig_q.push_back(req_digest[i*256 +: 256]);
          hs_cyc = cyc;
        end
      if (core_i_valid) begin blk_q.push_back(core_block); civ_cyc = cyc; end
      if (core_o_valid) ov_cyc = cyc;
      if (res_valid && !rv_prev) rv_cyc = cyc;
      if (res_valid && res_ready) res_q.push_back({res_id, res_hash});
    end
    rv_prev = res_valid;
  end

  // Requesters: present the head of each pending queue, hold it until the handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_n[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      req_valid[i] = (pend[i].size() > 0);
      req_digest[i*256 +: 256] = req_valid[i] ? pend[i][0] : '0;
    end
  end

  task automatic reset_dut();
    @(posedge clk); #2;
    rst_n = 1'b0; res_ready = 1'b0; inj = 1'b0;
    for (int i = 0; i < N; i++) pend[i].delete();
    repeat (3) @(posedge clk);
    #2;
    grant_q.delete(); idig_q.delete(); blk_q.delete(); res_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_res(input int n, input int budget, input string nm);
    int t = 0;
    while (res_q.size() < n && t < budget) begin @(negedge clk); t++; end
    checks++;
    if (res_q.size() < n) begin
      failures++;
      $display("FAIL %s timeout results=%0d need=%0d", nm, res_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++;
    if ({req_ready, core_i_valid, res_valid, res_id, err_orphan} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=0", {req_ready, core_i_valid, res_valid, res_id, err_orphan});
    end
    checks++;
    if (core_block !== '0) begin failures++; $display("FAIL reset_block got=%h exp=0", core_block); end
    checks++;
    if (res_hash !== '0) begin failures++; $display("FAIL reset_hash got=%h exp=0", res_hash); end
  endtask

  task automatic test_single();
    reset_dut();
    res_ready = 1'b1;
    pend[0].push_back(EMPTY_D);
    wait_res(1, 50, "single");
    checks++;
    if (blk_q.size() != 1 || blk_q[0] !== {EMPTY_D, TAIL}) begin
      failures++; $display("FAIL single_block n=%0d got=%h exp=%h", blk_q.size(), blk_q[0], {EMPTY_D, TAIL});
    end
    checks++;
    if (civ_cyc - hs_cyc != 1) begin failures++; $display("FAIL single_issue_lat got=%0d exp=1", civ_cyc - hs_cyc); end
    checks++;
    if (rv_cyc - ov_cyc != 1) begin failures++; $display("FAIL single_res_lat got=%0d exp=1", rv_cyc - ov_cyc); end
    checks++;
    if (res_q[0] !== {2'd0, KNOWN_H}) begin failures++; $display("FAIL single_result got=%h exp=%h", res_q[0], {2'd0, KNOWN_H}); end
  endtask

  task automatic test_fairness();
    logic [255:0] d;
    reset_dut();
    res_ready = 1'b1;
    for (int k = 0; k < 2; k++) for (int i = 0; i < N; i++) pend[i].push_back(mk(i, k));
    wait_res(8, 100, "fair");
    for (int j = 0; j < 8; j++) begin
      d = mk(j % 4, j / 4);
      checks++;
      if (grant_q[j] != j % 4) begin failures++; $display("FAIL fair_grant%0d got=%0d exp=%0d", j, grant_q[j], j % 4); end
      checks++;
      if (res_q[j] !== {IDW'(j % 4), d[255:96]}) begin
        failures++; $display("FAIL fair_res%0d got=%h exp=%h", j, res_q[j], {IDW'(j % 4), d[255:96]});
      end
    end
  endtask

  // Results must follow issue order, carry the granted id, and hold that requester's digest.
  task automatic check_order_inline_credit(input int n);
  endtask

  task automatic test_credit_stall();
    reset_dut();
    for (int k = 0; k < 3; k++) for (int i = 0; i < N; i++) pend[i].push_back(mk(i, k + 4));
    repeat (40) @(negedge clk);
    checks++;
    if (grant_q.size() != 8) begin failures++; $display("FAIL credit_issued got=%0d exp=8", grant_q.size()); end
    checks++;
    if (req_ready !== '0 || req_valid === '0) begin failures++; $display("FAIL credit_ready got=%b valid=%b exp=0", req_ready, req_valid); end
    @(posedge clk); #2 res_ready = 1'b1;
    @(posedge clk); #2 res_ready = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (grant_q.size() != 9) begin failures++; $display("FAIL credit_one_more got=%0d exp=9", grant_q.size()); end
    checks++;
    if (req_ready !== '0) begin failures++; $display("FAIL credit_ready2 got=%b exp=0", req_ready); end
    res_ready = 1'b1;
    wait_res(12, 200, "credit");
    for (int j = 0; j < 12 && j < res_q.size(); j++) begin
      checks++;
      if (res_q[j] !== {IDW'(grant_q[j]), idig_q[j][255:96]} || idig_q[j][255:248] != 8'(grant_q[j])) begin
        failures++; $display("FAIL credit_res%0d got=%h exp=%h", j, res_q[j], {IDW'(grant_q[j]), idig_q[j][255:96]});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [IDW+159:0] prev = '0;
    bit pstall = 0;
    reset_dut();
    for (int j = 0; j < 16; j++) pend[$urandom_range(0, N - 1)].push_back(mk(j % 4, j + 16));
    for (int t = 0; t < 800 && res_q.size() < 16; t++) begin
      @(negedge clk);
      if (pstall) begin
        checks++;
        if ({res_valid, res_id, res_hash} !== {1'b1, prev}) begin
          failures++; $display("FAIL bp_stable got=%h exp=%h", {res_valid, res_id, res_hash}, {1'b1, prev});
        end
      end
      pstall = res_valid && !res_ready;
      prev   = {res_id, res_hash};
      @(posedge clk); #2 res_ready = 1'($urandom_range(0, 1));
    end
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (res_q.size() != 16) begin failures++; $display("FAIL bp_count got=%0d exp=16", res_q.size()); end
    for (int j = 0; j < 16 && j < res_q.size(); j++) begin
      checks++;
      if (res_q[j] !== {IDW'(grant_q[j]), idig_q[j][255:96]}) begin
        failures++; $display("FAIL bp_res%0d got=%h exp=%h", j, res_q[j], {IDW'(grant_q[j]), idig_q[j][255:96]});
      end
    end
  endtask

  task automatic test_same_cycle();
    reset_dut();
    for (int j = 0; j < 7; j++) pend[j % 4].push_back(mk(j % 4, j + 40));
    repeat (30) @(negedge clk);
    checks++;
    if (grant_q.size() != 7 || res_valid !== 1'b1) begin
      failures++; $display("FAIL same_fill got=%0d/%b exp=7/1", grant_q.size(), res_valid);
    end
    @(posedge clk); #2;
    for (int j = 7; j < 17; j++) pend[j % 4].push_back(mk(j % 4, j + 40));
    @(posedge clk); #2 res_ready = 1'b1;
    wait_res(17, 300, "same");
    res_ready = 1'b0;
    for (int j = 17; j < 27; j++) pend[j % 4].push_back(mk(j % 4, j + 40));
    repeat (40) @(negedge clk);
    checks++;
    if (grant_q.size() != 25) begin failures++; $display("FAIL same_credit got=%0d exp=25", grant_q.size()); end
    res_ready = 1'b1;
    wait_res(27, 200, "same_drain");
    for (int j = 0; j < 27 && j < res_q.size(); j++) begin
      checks++;
      if (res_q[j] !== {IDW'(grant_q[j]), idig_q[j][255:96]} || idig_q[j][255:248] != 8'(grant_q[j])) begin
        failures++; $display("FAIL same_res%0d got=%h exp=%h", j, res_q[j], {IDW'(grant_q[j]), idig_q[j][255:96]});
      end
    end
  endtask

  task automatic test_orphan();
    logic [255:0] d;
    reset_dut();
    @(posedge clk); #2 inj = 1'b1;
    @(posedge clk); #2 inj = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_flag got=%b exp=1", err_orphan); end
    checks++;
    if (res_valid !== 1'b0 || res_q.size() != 0) begin failures++; $display("FAIL orphan_res got=%b exp=0", res_valid); end
    res_ready = 1'b1;
    d = mk(2, 99);
    pend[2].push_back(d);
    wait_res(1, 50, "orphan");
    checks++;
    if (res_q[0] !== {2'd2, d[255:96]}) begin failures++; $display("FAIL orphan_after got=%h exp=%h", res_q[0], {2'd2, d[255:96]}); end
    checks++;
    if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int j = 0; j < 8; j++) pend[j % 4].push_back(mk(j % 4, j + 80));
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) pend[i].delete();
    @(negedge clk);
    checks++;
    if ({core_i_valid, res_valid, res_id, err_orphan, core_block, res_hash} !== '0) begin
      failures++; $display("FAIL midrst_outputs vld=%b rv=%b id=%0d", core_i_valid, res_valid, res_id);
    end
    repeat (2) @(posedge clk);
    #2;
    grant_q.delete(); res_q.delete(); blk_q.delete(); idig_q.delete();
    rst_n = 1'b1; res_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, core_i_valid, res_valid, err_orphan} !== '0) begin
        failures++; $display("FAIL midrst_quiet%0d got=%h exp=0", t, {req_ready, core_i_valid, res_valid, err_orphan});
      end
    end
    checks++;
    if (res_q.size() != 0 || blk_q.size() != 0) begin failures++; $display("FAIL midrst_leak res=%0d blk=%0d exp=0", res_q.size(), blk_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_credit_stall();
    test_backpressure();
    test_same_cycle();
    test_orphan();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
